// File: rtl/fifo_ptr_flags.sv
// Read/write pointer and status-flag generator for a small dual-port-RAM FIFO.
// Wrap-phase bits on each pointer separate full from empty; every output is registered.
module fifo_ptr_flags #(
    parameter int ADDR_W    = 2,
    parameter int DEPTH     = 4,
    parameter int AEMPTY_TH = 1,
    parameter int AFULL_TH  = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              wr_en_i,
    input  logic              rd_en_i,
    output logic [ADDR_W-1:0] wr_ptr_o,
    output logic [ADDR_W-1:0] rd_ptr_o,
    output logic              wr_phase_o,
    output logic              rd_phase_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              almost_empty_o,
    output logic              almost_full_o,
    output logic [ADDR_W:0]   level_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   AE_TH    = (ADDR_W + 1)'(AEMPTY_TH);
    localparam logic [ADDR_W:0]   AF_TH    = (ADDR_W + 1)'(AFULL_TH);
    // Almost-flag values at level 0, shared by reset and clear.
    localparam logic              AE_RST   = (AEMPTY_TH >= 0);
    localparam logic              AF_RST   = (AFULL_TH <= 0);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic              wr_phase_q, wr_phase_d;
    logic              rd_phase_q, rd_phase_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              aempty_q, aempty_d;
    logic              afull_q, afull_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic wr_acc;
    logic rd_acc;

    assign wr_acc = wr_en_i & ~full_q & ~clear_i;
    assign rd_acc = rd_en_i & ~empty_q & ~clear_i;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        wr_phase_d  = wr_phase_q;
        rd_ptr_d    = rd_ptr_q;
        rd_phase_d  = rd_phase_q;
        overflow_d  = overflow_q | (wr_en_i & full_q);
        underflow_d = underflow_q | (rd_en_i & empty_q);

        if (wr_acc) begin
            if (wr_ptr_q == LAST_PTR) begin
                wr_ptr_d   = '0;
                wr_phase_d = ~wr_phase_q;
            end else begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
        end

        if (rd_acc) begin
            if (rd_ptr_q == LAST_PTR) begin
                rd_ptr_d   = '0;
                rd_phase_d = ~rd_phase_q;
            end else begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end

        if (clear_i) begin
            wr_ptr_d    = '0;
            wr_phase_d  = 1'b0;
            rd_ptr_d    = '0;
            rd_phase_d  = 1'b0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end

        // Flags follow the next-state pointers so they move on the same edge.
        empty_d = (wr_ptr_d == rd_ptr_d) & (wr_phase_d == rd_phase_d);
        full_d  = (wr_ptr_d == rd_ptr_d) & (wr_phase_d != rd_phase_d);

        if (wr_phase_d == rd_phase_d) begin
            level_d = {1'b0, wr_ptr_d} - {1'b0, rd_ptr_d};
        end else begin
            level_d = DEPTH_W - {1'b0, rd_ptr_d} + {1'b0, wr_ptr_d};
        end

        aempty_d = (level_d <= AE_TH);
        afull_d  = (level_d >= AF_TH);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            wr_phase_q  <= 1'b0;
            rd_phase_q  <= 1'b0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            aempty_q    <= AE_RST;
            afull_q     <= AF_RST;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_phase_q  <= wr_phase_d;
            rd_phase_q  <= rd_phase_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            aempty_q    <= aempty_d;
            afull_q     <= afull_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign wr_ptr_o       = wr_ptr_q;
    assign rd_ptr_o       = rd_ptr_q;
    assign wr_phase_o     = wr_phase_q;
    assign rd_phase_o     = rd_phase_q;
    assign empty_o        = empty_q;
    assign full_o         = full_q;
    assign almost_empty_o = aempty_q;
    assign almost_full_o  = afull_q;
    assign level_o        = level_q;
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;

endmodule
